// File: rtl/gf_mult_seq_if.sv
// Operand/result handshake bundle for gf_mult_seq.
// The requester uses the master modport and the multiplier uses the slave modport.
interface gf_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             busy;

  modport master (
    output in_valid, a, b, acc, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, acc, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/gf_mult_seq.sv
// Sequential digit-serial GF(2^WIDTH) multiplier with an optional XOR-accumulate of successive products.
// The product register is also the accumulator for the next acc=1 operation.
module gf_mult_seq #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1B,
  parameter int               DIGIT = 1
) (
  input logic          clk,
  input logic          rst,
  gf_mult_seq_if.slave bus
);

  localparam int L     = WIDTH / DIGIT;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("gf_mult_seq: WIDTH must be at least 2");
  end
  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("gf_mult_seq: DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_acc;
  logic [WIDTH-1:0] r_product;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_p_next;
  logic [WIDTH-1:0] w_b_next;

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] sh;
    sh = {x[WIDTH-2:0], 1'b0};
    if (x[WIDTH-1]) begin
      xtime = sh ^ POLY;
    end else begin
      xtime = sh;
    end
  endfunction

  // r_b is shifted left as bits are consumed, so its MSB is always the next multiplier bit.
  always_comb begin
    w_p_next = r_p;
    w_b_next = r_b;
    for (int i = 0; i < DIGIT; i++) begin
      if (w_b_next[WIDTH-1]) begin
        w_p_next = xtime(w_p_next) ^ r_a;
      end else begin
        w_p_next = xtime(w_p_next);
      end
      w_b_next = {w_b_next[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_acc       <= 1'b0;
      r_product   <= {WIDTH{1'b0}};
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_p         <= {WIDTH{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_acc      <= bus.acc;
            r_p        <= {WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_p   <= w_p_next;
          r_b   <= w_b_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_product   <= w_p_next ^ (r_acc ? r_product : {WIDTH{1'b0}});
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_product;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Directed self-checking bench for gf_mult_seq: AES field vectors, accumulate chain,
// backpressure, reset during an operation and three parameter variants.
module tb_gf_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gf_mult_seq_if #(.WIDTH(8)) if_d1 ();
  gf_mult_seq_if #(.WIDTH(8)) if_d8 ();
  gf_mult_seq_if #(.WIDTH(8)) if_d4 ();
  gf_mult_seq_if #(.WIDTH(4)) if_w4 ();

  gf_mult_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(1)) u_dut_d1 (.clk(clk), .rst(rst), .bus(if_d1));
  gf_mult_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(8)) u_dut_d8 (.clk(clk), .rst(rst), .bus(if_d8));
  gf_mult_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(4)) u_dut_d4 (.clk(clk), .rst(rst), .bus(if_d4));
  gf_mult_seq #(.WIDTH(4), .POLY(4'h3), .DIGIT(1)) u_dut_w4 (.clk(clk), .rst(rst), .bus(if_w4));

  task automatic drive8(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic acc);
    if (sel == 0) begin
      if_d1.in_valid = v; if_d1.a = a; if_d1.b = b; if_d1.acc = acc;
    end else if (sel == 1) begin
      if_d8.in_valid = v; if_d8.a = a; if_d8.b = b; if_d8.acc = acc;
    end else begin
      if_d4.in_valid = v; if_d4.a = a; if_d4.b = b; if_d4.acc = acc;
    end
  endtask

  function automatic logic ov8(input int sel);
    if (sel == 0) return if_d1.out_valid;
    else if (sel == 1) return if_d8.out_valid;
    else return if_d4.out_valid;
  endfunction

  function automatic logic [7:0] prod8(input int sel);
    if (sel == 0) return if_d1.product;
    else if (sel == 1) return if_d8.product;
    else return if_d4.product;
  endfunction

  // One full transaction with out_ready held high; lat = edges from accept to out_valid (-1 on timeout).
  task automatic op8(input int sel, input logic [7:0] a, input logic [7:0] b, input logic acc,
                     output logic [7:0] res, output int lat);
    lat = -1;
    res = 8'h00;
    @(negedge clk);
    drive8(sel, 1'b1, a, b, acc);
    @(posedge clk); #1;
    drive8(sel, 1'b0, ~a, ~b, ~acc);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ov8(sel)) begin
        lat = n;
        res = prod8(sel);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, output logic [3:0] res,
                     output int lat);
    lat = -1;
    res = 4'h0;
    @(negedge clk);
    if_w4.in_valid = 1'b1; if_w4.a = a; if_w4.b = b; if_w4.acc = 1'b0;
    @(posedge clk); #1;
    if_w4.in_valid = 1'b0; if_w4.a = ~a; if_w4.b = ~b;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (if_w4.out_valid) begin
        lat = n;
        res = if_w4.product;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (if_d1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", if_d1.in_ready); end
    total++; if (if_d1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", if_d1.out_valid); end
    total++; if (if_d1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", if_d1.busy); end
    total++; if (if_d1.product !== 8'h00) begin bad++; $display("FAIL reset_product: got %h want 00", if_d1.product); end
    total++; if (if_w4.product !== 4'h0 || if_w4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_w4: got prod=%h rdy=%b want 0/1", if_w4.product, if_w4.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] res;
    int lat;
    op8(0, 8'h57, 8'h13, 1'b0, res, lat);
    total++; if (res !== 8'hFE) begin bad++; $display("FAIL basic_57x13: got %h want fe", res); end
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
    total++; if (if_d1.out_valid !== 1'b0 || if_d1.in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_after: got ov=%b rdy=%b want 0/1", if_d1.out_valid, if_d1.in_ready); end
    op8(0, 8'h57, 8'h83, 1'b0, res, lat);
    total++; if (res !== 8'hC1) begin bad++; $display("FAIL basic_57x83: got %h want c1", res); end
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency2: got %0d want 8", lat); end
  endtask

  task automatic test_unsupported();
    logic [7:0] res;
    int lat;
    op8(0, 8'h57, 8'h07, 1'b0, res, lat);
    total++; if (res !== 8'hBE) begin bad++; $display("FAIL mul_57x07: got %h want be", res); end
    op8(0, 8'h57, 8'h00, 1'b0, res, lat);
    total++; if (res !== 8'h00) begin bad++; $display("FAIL mul_57x00: got %h want 00", res); end
    op8(0, 8'hFF, 8'h01, 1'b0, res, lat);
    total++; if (res !== 8'hFF) begin bad++; $display("FAIL mul_ffx01: got %h want ff", res); end
    op8(0, 8'h00, 8'h35, 1'b1, res, lat);
    total++; if (res !== 8'hFF) begin bad++; $display("FAIL acc_a_zero: got %h want ff", res); end
  endtask

  task automatic test_accumulate();
    logic [7:0] res;
    int lat;
    op8(0, 8'hD4, 8'h02, 1'b0, res, lat);
    total++; if (res !== 8'hB3) begin bad++; $display("FAIL mix_step1: got %h want b3", res); end
    op8(0, 8'hBF, 8'h03, 1'b1, res, lat);
    total++; if (res !== 8'h69) begin bad++; $display("FAIL mix_step2: got %h want 69", res); end
    op8(0, 8'h5D, 8'h01, 1'b1, res, lat);
    total++; if (res !== 8'h34) begin bad++; $display("FAIL mix_step3: got %h want 34", res); end
    op8(0, 8'h30, 8'h01, 1'b1, res, lat);
    total++; if (res !== 8'h04) begin bad++; $display("FAIL mix_step4: got %h want 04", res); end
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    if_d1.out_ready = 1'b0;
    @(negedge clk);
    drive8(0, 1'b1, 8'h57, 8'h13, 1'b0);
    @(posedge clk); #1;
    drive8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (if_d1.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", seen); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive8(0, ((k % 2) == 0), 8'h11 + 8'(k), 8'h22 + 8'(k), 1'b1);
      @(posedge clk); #1;
      total++; if (if_d1.product !== 8'hFE) begin bad++; $display("FAIL bp_product_stable: got %h want fe", if_d1.product); end
      total++; if (if_d1.out_valid !== 1'b1 || if_d1.in_ready !== 1'b0 || if_d1.busy !== 1'b1) begin bad++; $display("FAIL bp_flags: got ov=%b rdy=%b busy=%b want 1/0/1", if_d1.out_valid, if_d1.in_ready, if_d1.busy); end
    end
    @(negedge clk);
    drive8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    if_d1.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (if_d1.out_valid !== 1'b0 || if_d1.in_ready !== 1'b1 || if_d1.busy !== 1'b0) begin bad++; $display("FAIL bp_release: got ov=%b rdy=%b busy=%b want 0/1/0", if_d1.out_valid, if_d1.in_ready, if_d1.busy); end
    total++; if (if_d1.product !== 8'hFE) begin bad++; $display("FAIL bp_product_kept: got %h want fe", if_d1.product); end
  endtask

  task automatic test_reset_mid_busy();
    logic [7:0] res;
    int lat;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    drive8(0, 1'b1, 8'h57, 8'h13, 1'b0);
    @(posedge clk); #1;
    drive8(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (if_d1.in_ready !== 1'b1 || if_d1.busy !== 1'b0) begin bad++; $display("FAIL rst_busy_flags: got rdy=%b busy=%b want 1/0", if_d1.in_ready, if_d1.busy); end
    total++; if (if_d1.product !== 8'h00) begin bad++; $display("FAIL rst_busy_product: got %h want 00", if_d1.product); end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if_d1.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_busy_no_pulse: got %b want 0", seen); end
    op8(0, 8'hCA, 8'h02, 1'b1, res, lat);
    total++; if (res !== 8'h8F) begin bad++; $display("FAIL rst_then_acc: got %h want 8f", res); end
  endtask

  task automatic test_param_sweep();
    logic [7:0] res;
    logic [3:0] res4;
    int lat;
    op8(1, 8'hFF, 8'h0E, 1'b0, res, lat);
    total++; if (res !== 8'h8D) begin bad++; $display("FAIL d8_ffx0e: got %h want 8d", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL d8_latency: got %0d want 1", lat); end
    op8(2, 8'h83, 8'h0D, 1'b0, res, lat);
    total++; if (res !== 8'hCD) begin bad++; $display("FAIL d4_83x0d: got %h want cd", res); end
    total++; if (lat !== 2) begin bad++; $display("FAIL d4_latency: got %0d want 2", lat); end
    op8(2, 8'h57, 8'h13, 1'b1, res, lat);
    total++; if (res !== 8'h33) begin bad++; $display("FAIL d4_acc: got %h want 33", res); end
    op4(4'h8, 4'h2, res4, lat);
    total++; if (res4 !== 4'h3) begin bad++; $display("FAIL w4_8x2: got %h want 3", res4); end
    total++; if (lat !== 4) begin bad++; $display("FAIL w4_latency: got %0d want 4", lat); end
    op4(4'hF, 4'hF, res4, lat);
    total++; if (res4 !== 4'hA) begin bad++; $display("FAIL w4_fxf: got %h want a", res4); end
  endtask

  initial begin
    if_d1.in_valid = 1'b0; if_d1.a = 8'h00; if_d1.b = 8'h00; if_d1.acc = 1'b0; if_d1.out_ready = 1'b1;
    if_d8.in_valid = 1'b0; if_d8.a = 8'h00; if_d8.b = 8'h00; if_d8.acc = 1'b0; if_d8.out_ready = 1'b1;
    if_d4.in_valid = 1'b0; if_d4.a = 8'h00; if_d4.b = 8'h00; if_d4.acc = 1'b0; if_d4.out_ready = 1'b1;
    if_w4.in_valid = 1'b0; if_w4.a = 4'h0;  if_w4.b = 4'h0;  if_w4.acc = 1'b0; if_w4.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_unsupported();
    test_accumulate();
    test_backpressure();
    test_reset_mid_busy();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/gf_mult_seq.md
Name: gf_mult_seq

Overview:
Sequential, parametrised GF(2^WIDTH) multiplier with valid/ready handshakes. It accepts any pair of operands, including the multiplier values 0x00 and 0x07 that the constant-coefficient multiplier does not support. It adds an accumulate mode that XORs successive products, so one MixColumns or InvMixColumns dot product can be computed without external XOR logic. It processes DIGIT multiplier bits per cycle, trading latency for area. It serves as the shared multiply engine for the AES datapath and for key-schedule and test utilities.

Parameters:
WIDTH, 8, field width m in bits; WIDTH >= 2.
POLY, 8'h1B, low WIDTH bits of the irreducible polynomial; the x^WIDTH term is implicit (default x^8+x^4+x^3+x+1).
DIGIT, 1, multiplier bits processed per cycle; WIDTH % DIGIT == 0 is required, with an elaboration-time $error otherwise.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous and active-high.
in_valid  in  1  operands are presented.
in_ready  out  1  block can accept operands.
a  in  WIDTH  multiplicand.
b  in  WIDTH  multiplier.
acc  in  1  1 = XOR the new product into the previous result; 0 = fresh product.
out_valid  out  1  result is available.
out_ready  in  1  consumer accepts the result.
product  out  WIDTH  result (a*b, or prev_result ^ a*b when acc=1).
busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator register=0, internal a/b/p/counter=0.
- States: IDLE, BUSY, DONE. L = WIDTH/DIGIT.
- IDLE: in_ready=1. Accept edge = in_valid & in_ready. On accept, capture a, b, acc; set p=0, cnt=0; go to BUSY.
- BUSY: in_ready=0. Each edge applies DIGIT Horner steps, MSB of b first:
  - p = xtime(p) ^ (b[i] ? a : 0), for i descending.
  - xtime(x) = (x<<1) truncated to WIDTH bits, ^ POLY if x[WIDTH-1]=1.
  - cnt increments each edge.
- BUSY exit: after the L-th BUSY edge, product = p_final ^ (acc_captured ? product_prev : 0); go to DONE.
- Latency: out_valid rises exactly L edges after the accept edge (DIGIT=1, WIDTH=8 gives 8; DIGIT=WIDTH gives 1).
- DONE: out_valid=1, in_ready=0. product holds stable while out_valid & !out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid=0.
  - product keeps its value after handshake; it is the accumulator source for the next acc=1 operation.
- in_valid asserted during BUSY/DONE is ignored (not captured). Minimum spacing between accepts is L+2 cycles when out_ready is held at 1.
- acc=1 as the first operation after reset accumulates with 0.
- b=0 gives a product of 0 (or the unchanged accumulator when acc=1). a=0 likewise.
- Inputs a/b/acc may change freely after the accept edge; the captured copies are used.
- Reset asserted mid-BUSY or mid-DONE: the operation is abandoned, all state follows the reset values above, and no out_valid pulse is produced.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x57, b=0x13, acc=0, out_ready=1 -> product=0xFE with out_valid exactly 8 cycles after accept. Repeat a=0x57, b=0x83 -> 0xC1.
- Unsupported-by-constant cases: a=0x57, b=0x07 -> 0xBE. a=0x57, b=0x00 -> 0x00. a=0xFF, b=0x01 -> 0xFF.
- Accumulate (FIPS-197 MixColumns), four ops in sequence:
  - (0xD4,0x02,acc=0) -> 0xB3
  - (0xBF,0x03,acc=1) -> 0x69
  - (0x5D,0x01,acc=1) -> 0x34
  - (0x30,0x01,acc=1) -> 0x04
- Backpressure: out_ready=0 for 5 cycles after out_valid, toggling in_valid and a/b meanwhile -> product stable, in_ready=0, no new accept; handshake then returns to IDLE.
- Reset mid-BUSY on cycle 3 of a 0x57*0x13 operation -> out_valid stays 0, product=0, in_ready=1 immediately. The next acc=1 op (0xCA,0x02) -> 0x8F.
- Parameter sweep:
  - DIGIT=8 -> latency 1, 0xFF*0x0E=0x8D.
  - DIGIT=4 -> latency 2, 0x83*0x0D=0xCD.
  - WIDTH=4, POLY=4'h3 -> 0x8*0x2=0x3 and 0xF*0xF=0xA.
